// File: rtl/ahbl_uart_rx_pkg.sv
// Shared definitions for the AHB-Lite UART receiver: register map, FSM states, bus payload.
package ahbl_uart_rx_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PRESC_W = 16;
    localparam int unsigned TICK_W  = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BIT_W   = 3;

    // Word offsets decoded from HADDR[3:2]
    localparam logic [1:0] REG_DATA     = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_PRESCALE = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    // Oversample tick thresholds: mid start bit, then one full bit period
    localparam logic [TICK_W-1:0] HALF_BIT_LAST = 4'd7;
    localparam logic [TICK_W-1:0] FULL_BIT_LAST = 4'd15;
    localparam logic [BIT_W-1:0]  LAST_DATA_BIT = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Registered AHB address phase
    typedef struct packed {
        logic       valid;
        logic       write;
        logic [1:0] addr;
    } ahb_aphase_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_c  = pop & ~empty;
    assign do_push_c = push & (~full | do_pop_c);
    assign dout      = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // Storage; contents are only meaningful behind the pointers
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver: 8N1 at 16x oversampling, receive FIFO, status/IRQ registers.
module ahbl_uart_rx
    import ahbl_uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic              HSEL,
    input  logic [31:0]       HWDATA,
    output logic              HREADYOUT,
    output logic [DATA_W-1:0] HRDATA,
    input  logic              rx,
    output logic              IRQ
);

    ahb_aphase_t        aph_q;
    logic [PRESC_W-1:0] prescale_q;
    logic [PRESC_W-1:0] presc_cnt_q;
    logic               en_q;
    logic               irq_en_q;
    logic               ovr_q;
    logic               ferr_q;
    logic               irq_q;
    logic               rx_meta_q;
    logic               rx_sync_q;
    logic               rx_prev_q;
    rx_state_e          state_q;
    rx_state_e          state_d;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [BYTE_W-1:0]  shift_q;

    logic               rd_c;
    logic               wr_c;
    logic               pop_c;
    logic               tick_c;
    logic               fall_c;
    logic               sample_c;
    logic               push_c;
    logic               ferr_set_c;
    logic               ovr_set_c;
    logic [BYTE_W-1:0]  fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic               unused_ok;

    assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    assign HREADYOUT = 1'b1;
    assign IRQ       = irq_q;

    assign wr_c      = aph_q.valid & aph_q.write;
    assign rd_c      = aph_q.valid & ~aph_q.write;
    assign pop_c     = rd_c & (aph_q.addr == REG_DATA) & ~fifo_empty;
    assign tick_c    = en_q & (presc_cnt_q >= prescale_q);
    assign fall_c    = rx_prev_q & ~rx_sync_q;
    assign ovr_set_c = push_c & fifo_full & ~pop_c;

    // Capture the address phase for the following data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            aph_q <= '0;
        end else begin
            aph_q.valid <= HSEL & HREADY & HTRANS[1];
            aph_q.write <= HWRITE;
            aph_q.addr  <= HADDR[3:2];
        end
    end

    // Read mux, valid during the data phase of a read
    always_comb begin
        HRDATA = '0;
        if (rd_c) begin
            case (aph_q.addr)
                REG_DATA:     HRDATA = fifo_empty ? '0 : DATA_W'(fifo_dout);
                REG_STATUS:   HRDATA = DATA_W'({ferr_q, ovr_q, fifo_full, ~fifo_empty});
                REG_PRESCALE: HRDATA = DATA_W'(prescale_q);
                default:      HRDATA = DATA_W'({irq_en_q, en_q});
            endcase
        end
    end

    // Control registers, sticky flags and the registered interrupt
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prescale_q <= '0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_c && aph_q.addr == REG_PRESCALE) prescale_q <= HWDATA[PRESC_W-1:0];
            if (wr_c && aph_q.addr == REG_CTRL) begin
                en_q     <= HWDATA[0];
                irq_en_q <= HWDATA[1];
            end
            // Set has priority over write-one-to-clear
            if (ovr_set_c)                                        ovr_q  <= 1'b1;
            else if (wr_c && aph_q.addr == REG_STATUS && HWDATA[2]) ovr_q  <= 1'b0;
            if (ferr_set_c)                                       ferr_q <= 1'b1;
            else if (wr_c && aph_q.addr == REG_STATUS && HWDATA[3]) ferr_q <= 1'b0;
            irq_q <= irq_en_q & (~fifo_empty | ovr_q | ferr_q);
        end
    end

    // Two-flop synchronizer plus previous value for edge detection
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Prescaler and oversample tick counter; idle/disabled keeps them at zero to align with the start edge
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc_cnt_q <= '0;
            tick_cnt_q  <= '0;
        end else if (!en_q || state_q == RX_IDLE) begin
            presc_cnt_q <= '0;
            tick_cnt_q  <= '0;
        end else begin
            presc_cnt_q <= tick_c ? '0 : presc_cnt_q + PRESC_W'(1);
            if (sample_c)    tick_cnt_q <= '0;
            else if (tick_c) tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Data bit counter and LSB-first shift register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (state_q == RX_IDLE) begin
            bit_cnt_q <= '0;
        end else if (sample_c && state_q == RX_DATA) begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            shift_q   <= {rx_sync_q, shift_q[BYTE_W-1:1]};
        end
    end

    // RX FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= RX_IDLE;
        else          state_q <= state_d;
    end

    // RX FSM next state and per-cycle strobes
    always_comb begin
        state_d    = state_q;
        sample_c   = 1'b0;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall_c) state_d = RX_START;
            end
            RX_START: begin
                if (tick_c && tick_cnt_q == HALF_BIT_LAST) begin
                    sample_c = 1'b1;
                    state_d  = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_c && tick_cnt_q == FULL_BIT_LAST) begin
                    sample_c = 1'b1;
                    if (bit_cnt_q == LAST_DATA_BIT) state_d = RX_STOP;
                end
            end
            default: begin
                if (tick_c && tick_cnt_q == FULL_BIT_LAST) begin
                    sample_c   = 1'b1;
                    state_d    = RX_IDLE;
                    push_c     = rx_sync_q;
                    ferr_set_c = ~rx_sync_q;
                end
            end
        endcase
        if (!en_q) begin
            state_d    = RX_IDLE;
            sample_c   = 1'b0;
            push_c     = 1'b0;
            ferr_set_c = 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (push_c),
        .pop   (pop_c),
        .din   (shift_q),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
